// File: rtl/ccip_rd_arbiter_pkg.sv
// Shared CCI-P c0 types, arbiter FSM encodings and size defaults for the
// c0 read-request arbiter. Field layout follows the CCI-P c0 headers.
package ccip_rd_arbiter_pkg;

   localparam int CCIP_RD_ARB_N_REQ      = 4;
   localparam int CCIP_RD_ARB_LMAX_OUTST = 6;

   typedef logic [41:0]  t_ccip_clAddr;
   typedef logic [15:0]  t_ccip_mdata;
   typedef logic [511:0] t_ccip_clData;

   typedef enum logic [1:0] {
      eVC_VA  = 2'd0,
      eVC_VL0 = 2'd1,
      eVC_VH0 = 2'd2,
      eVC_VH1 = 2'd3
   } t_ccip_vc;

   typedef enum logic [1:0] {
      eCL_LEN_1 = 2'd0,
      eCL_LEN_2 = 2'd1,
      eCL_LEN_4 = 2'd3
   } t_ccip_clLen;

   typedef enum logic [3:0] {
      eREQ_RDLINE_S = 4'h0,
      eREQ_RDLINE_I = 4'h1
   } t_ccip_c0_req;

   typedef enum logic [3:0] {
      eRSP_RDLINE = 4'h0,
      eRSP_UMSG   = 4'h4
   } t_ccip_c0_rsp;

   typedef struct packed {
      t_ccip_vc     vc_sel;
      logic [1:0]   rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_c0_req req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      t_ccip_vc     vc_used;
      logic         rsvd1;
      logic         hit_miss;
      logic [1:0]   rsvd0;
      logic [1:0]   cl_num;
      t_ccip_c0_rsp resp_type;
      t_ccip_mdata  mdata;
   } t_ccip_c0_RspMemHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c0_RspMemHdr hdr;
      t_ccip_clData       data;
      logic               rspValid;
      logic               mmioRdValid;
      logic               mmioWrValid;
   } t_if_ccip_c0_Rx;

   // Arbiter FSM encodings
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;
   localparam logic [1:0] ST_DRAINED = 2'd3;

   // True for a read-line completion on the c0 response channel
   function automatic logic is_rdline_rsp(input t_if_ccip_c0_Rx rx);
      return rx.rspValid && (rx.hdr.resp_type == eRSP_RDLINE);
   endfunction

endpackage

// File: rtl/ccip_rd_arbiter_if.sv
// Requester-side bundle of the c0 read arbiter: per-requester request
// valid/address/ready plus the steered response return.
interface ccip_rd_arbiter_if
   import ccip_rd_arbiter_pkg::*;
#(
   parameter int N_REQ = CCIP_RD_ARB_N_REQ
) ();

   logic [N_REQ-1:0]         req_valid;
   t_ccip_clAddr [N_REQ-1:0] req_addr;
   logic [N_REQ-1:0]         req_ready;
   logic [N_REQ-1:0]         rsp_valid;
   t_ccip_clData             rsp_data;

   // Fetch-engine side
   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   // Arbiter side
   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );

endinterface

// File: rtl/ccip_rd_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N. Shared between the c0 and c1 arbiters.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   // Scan from ptr upward and latch the first requester found
   always_comb begin
      logic          found_v;
      logic [IW-1:0] idx_v;
      int            sum_v;
      gnt     = {N{1'b0}};
      gnt_idx = {IW{1'b0}};
      found_v = 1'b0;
      idx_v   = {IW{1'b0}};
      sum_v   = 0;
      for (int k = 0; k < N; k++) begin
         sum_v = int'(ptr) + k;
         idx_v = (sum_v >= N) ? IW'(sum_v - N) : IW'(sum_v);
         if (!found_v && req[idx_v]) begin
            gnt[idx_v] = 1'b1;
            gnt_idx    = idx_v;
            found_v    = 1'b1;
         end else begin
            found_v = found_v;
         end
      end
   end

endmodule

// File: rtl/ccip_rd_arbiter.sv
// Shares the CCI-P c0 read-request channel between N_REQ fetch engines.
// Round-robin grant, mdata tagging with the requester index, credit-bounded
// outstanding reads and response steering by mdata.
module ccip_rd_arbiter
   import ccip_rd_arbiter_pkg::*;
#(
   parameter int N_REQ      = CCIP_RD_ARB_N_REQ,
   parameter int ID_W       = $clog2(N_REQ),
   parameter int MDATA_W    = 12,
   parameter int LMAX_OUTST = CCIP_RD_ARB_LMAX_OUTST
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  sRx_c0TxAlmFull,
   input  t_if_ccip_c0_Rx        sRx_c0,
   output t_if_ccip_c0_Tx        sTx_c0,
   ccip_rd_arbiter_if.slave      bus,
   output logic [LMAX_OUTST-1:0] outstanding,
   output logic                  drained,
   output logic                  error
);

   localparam logic [LMAX_OUTST-1:0] OUT_MAX  = {LMAX_OUTST{1'b1}};
   localparam logic [LMAX_OUTST-1:0] OUT_ZERO = {LMAX_OUTST{1'b0}};
   localparam logic [LMAX_OUTST-1:0] OUT_ONE  = LMAX_OUTST'(1'b1);

   logic [1:0]            state_r, state_nxt_s;
   logic [ID_W-1:0]       rr_ptr_r, gnt_idx_s;
   logic [N_REQ-1:0]      gnt_s;
   logic [LMAX_OUTST-1:0] out_r, out_nxt_s;
   logic                  issue_s;
   logic                  rsp_rdline_s, id_ok_s, rsp_accept_s;
   logic [MDATA_W-1:0]    rsp_tag_s;
   logic [ID_W-1:0]       rsp_id_s;
   logic [N_REQ-1:0]      rsp_onehot_s;
   t_ccip_c0_ReqMemHdr    req_hdr_s, tx_hdr_r;
   logic                  tx_valid_r;
   logic [N_REQ-1:0]      rsp_valid_r;
   t_ccip_clData          rsp_data_r;
   logic                  error_r;
   logic                  unused_rx_s;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req     (bus.req_valid),
      .ptr     (rr_ptr_r),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s)
   );

   // A grant needs RUN, enable still high, channel room and a free credit
   assign issue_s = (state_r == ST_RUN) && enable && !sRx_c0TxAlmFull &&
                    (out_r != OUT_MAX) && (|bus.req_valid);
   assign bus.req_ready = issue_s ? gnt_s : {N_REQ{1'b0}};

   // The tag field is range-checked as a whole so corrupted upper bits are caught
   assign rsp_rdline_s = is_rdline_rsp(sRx_c0);
   assign rsp_tag_s    = sRx_c0.hdr.mdata[MDATA_W-1:0];
   assign id_ok_s      = (rsp_tag_s < MDATA_W'(N_REQ));
   assign rsp_id_s     = rsp_tag_s[ID_W-1:0];
   assign rsp_accept_s = rsp_rdline_s && id_ok_s;

   // Response fields this block never looks at
   assign unused_rx_s = ^{sRx_c0.mmioRdValid, sRx_c0.mmioWrValid, sRx_c0.hdr.vc_used,
                          sRx_c0.hdr.rsvd1, sRx_c0.hdr.hit_miss, sRx_c0.hdr.rsvd0,
                          sRx_c0.hdr.cl_num, sRx_c0.hdr.mdata[15:MDATA_W]};

   // Build the RDLINE_I header for the granted requester
   always_comb begin
      req_hdr_s                 = '0;
      req_hdr_s.vc_sel          = eVC_VH0;
      req_hdr_s.cl_len          = eCL_LEN_1;
      req_hdr_s.req_type        = eREQ_RDLINE_I;
      req_hdr_s.address         = bus.req_addr[gnt_idx_s];
      req_hdr_s.mdata[ID_W-1:0] = gnt_idx_s;
   end

   // Next-state logic; re-enable always wins over draining
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) state_nxt_s = ST_RUN;
            else        state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (!enable) state_nxt_s = ST_DRAIN;
            else         state_nxt_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (enable)                                   state_nxt_s = ST_RUN;
            else if ((out_r == OUT_ZERO) && !rsp_rdline_s) state_nxt_s = ST_DRAINED;
            else                                          state_nxt_s = ST_DRAIN;
         end
         ST_DRAINED: begin
            if (enable) state_nxt_s = ST_RUN;
            else        state_nxt_s = ST_DRAINED;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Credit update: issue and completion cancel, completions never underflow
   always_comb begin
      if (issue_s && rsp_accept_s) begin
         out_nxt_s = out_r;
      end else if (issue_s) begin
         out_nxt_s = out_r + OUT_ONE;
      end else if (rsp_accept_s && (out_r != OUT_ZERO)) begin
         out_nxt_s = out_r - OUT_ONE;
      end else begin
         out_nxt_s = out_r;
      end
   end

   // One-hot decode of the response owner
   always_comb begin
      rsp_onehot_s = {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         rsp_onehot_s[i] = (rsp_id_s == ID_W'(i));
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_r <= ST_IDLE;
      else          state_r <= state_nxt_s;
   end

   // Round-robin pointer moves just past the winner on each issue
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_r <= {ID_W{1'b0}};
      end else if (issue_s) begin
         rr_ptr_r <= (gnt_idx_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : gnt_idx_s + ID_W'(1'b1);
      end
   end

   // Outstanding-read credit counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) out_r <= OUT_ZERO;
      else          out_r <= out_nxt_s;
   end

   // c0 TX register stage; header holds its last value while valid is low
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_valid_r <= 1'b0;
         tx_hdr_r   <= '0;
      end else begin
         tx_valid_r <= issue_s;
         if (issue_s) tx_hdr_r <= req_hdr_s;
      end
   end

   // Response demux: one-cycle steer to the tagged requester
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_r <= {N_REQ{1'b0}};
         rsp_data_r  <= '0;
      end else begin
         rsp_valid_r <= rsp_accept_s ? rsp_onehot_s : {N_REQ{1'b0}};
         if (rsp_accept_s) rsp_data_r <= sRx_c0.data;
      end
   end

   // Sticky error on completion underflow or an out-of-range tag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         error_r <= 1'b0;
      end else if (rsp_rdline_s && ((out_r == OUT_ZERO) || !id_ok_s)) begin
         error_r <= 1'b1;
      end
   end

   assign sTx_c0.valid  = tx_valid_r;
   assign sTx_c0.hdr    = tx_hdr_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
   assign outstanding   = out_r;
   assign drained       = (state_r == ST_DRAINED);
   assign error         = error_r;

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Self-checking bench for ccip_rd_arbiter: table of per-cycle vectors with
// expected grants/credits/flags, plus queues of expected c0 requests and
// steered responses that are checked one cycle after they are predicted.
`timescale 1ns/1ps
module tb_ccip_rd_arbiter;
   import ccip_rd_arbiter_pkg::*;

   localparam int N_REQ = 4;
   localparam int LMAX  = 3;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            enable;
   logic            almfull;
   t_if_ccip_c0_Rx  rx;
   t_if_ccip_c0_Tx  tx;
   logic [LMAX-1:0] outstanding;
   logic            drained;
   logic            error;

   ccip_rd_arbiter_if #(.N_REQ(N_REQ)) bus ();

   ccip_rd_arbiter #(.N_REQ(N_REQ), .ID_W(2), .MDATA_W(12), .LMAX_OUTST(LMAX)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .enable          (enable),
      .sRx_c0TxAlmFull (almfull),
      .sRx_c0          (rx),
      .sTx_c0          (tx),
      .bus             (bus),
      .outstanding     (outstanding),
      .drained         (drained),
      .error           (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         en;
      logic [3:0]   rv;
      logic         af;
      logic         rspv;
      t_ccip_c0_rsp rtype;
      logic [11:0]  rid;
      logic [3:0]   exp_ready;
      logic [2:0]   exp_out;
      logic         exp_drained;
      logic         exp_err;
   } vec_t;

   typedef struct {
      logic [3:0]   onehot;
      t_ccip_clData data;
   } rsp_exp_t;

   t_ccip_c0_ReqMemHdr txq[$];
   rsp_exp_t           rspq[$];
   vec_t               tbl[$];
   int                 total = 0;
   int                 bad   = 0;
   int                 step  = 0;

   function automatic t_ccip_clAddr addr_of(input int i);
      return 42'h1000 * 42'(i + 1) + 42'h7;
   endfunction

   function automatic vec_t mk(input logic en, input logic [3:0] rv, input logic af,
                               input logic rspv, input t_ccip_c0_rsp rtype, input logic [11:0] rid,
                               input logic [3:0] exp_ready, input logic [2:0] exp_out,
                               input logic exp_drained, input logic exp_err);
      vec_t v;
      v.en = en; v.rv = rv; v.af = af; v.rspv = rspv; v.rtype = rtype; v.rid = rid;
      v.exp_ready = exp_ready; v.exp_out = exp_out;
      v.exp_drained = exp_drained; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step=%0d got=%0h want=%0h", nm, step, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tx_valid"}, tx.valid, 1'b0);
      chk({tag, "_tx_hdr"}, tx.hdr, 74'h0);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 4'b0000);
      chk({tag, "_rsp_data"}, bus.rsp_data, 512'h0);
      chk({tag, "_outstanding"}, outstanding, 3'd0);
      chk({tag, "_drained"}, drained, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
   endtask

   // Drive one cycle of stimulus, check this cycle, predict the next one
   task automatic run_vec(input vec_t v);
      t_ccip_c0_ReqMemHdr eh;
      rsp_exp_t           er;
      int                 gi;
      enable            = v.en;
      bus.req_valid     = v.rv;
      almfull           = v.af;
      rx                = '0;
      rx.rspValid       = v.rspv;
      rx.hdr.resp_type  = v.rtype;
      rx.hdr.mdata      = {4'b0000, v.rid};
      rx.data           = {16{32'hA500_0000 + 32'(step)}};
      #2;
      chk("req_ready", bus.req_ready, v.exp_ready);
      chk("outstanding", outstanding, v.exp_out);
      chk("drained", drained, v.exp_drained);
      chk("error", error, v.exp_err);
      if (txq.size() > 0) begin
         eh = txq.pop_front();
         chk("tx_valid", tx.valid, 1'b1);
         chk("tx_hdr", tx.hdr, eh);
      end else begin
         chk("tx_idle", tx.valid, 1'b0);
      end
      if (rspq.size() > 0) begin
         er = rspq.pop_front();
         chk("rsp_valid", bus.rsp_valid, er.onehot);
         chk("rsp_data", bus.rsp_data, er.data);
      end else begin
         chk("rsp_idle", bus.rsp_valid, 4'b0000);
      end
      if (v.exp_ready != 4'b0000) begin
         gi = 0;
         for (int i = 0; i < N_REQ; i++) if (v.exp_ready[i]) gi = i;
         eh          = '0;
         eh.vc_sel   = eVC_VH0;
         eh.cl_len   = eCL_LEN_1;
         eh.req_type = eREQ_RDLINE_I;
         eh.address  = addr_of(gi);
         eh.mdata    = 16'(gi);
         txq.push_back(eh);
      end
      if (v.rspv && (v.rtype == eRSP_RDLINE) && (v.rid < 12'd4)) begin
         er.onehot = 4'b0001 << v.rid[1:0];
         er.data   = rx.data;
         rspq.push_back(er);
      end
      step++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      enable        = 1'b0;
      almfull       = 1'b0;
      bus.req_valid = 4'b0000;
      rx            = '0;
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      for (int i = 0; i < N_REQ; i++) bus.req_addr[i] = addr_of(i);

      // Full rotation, sparse requesters, almost-full stall, credit ceiling
      tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0000, 3'd0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0001, 3'd0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0010, 3'd1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0100, 3'd2, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b1000, 3'd3, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0001, 3'd4, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0101, 1'b0, 1'b1, eRSP_RDLINE, 12'd0, 4'b0100, 3'd5, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0101, 1'b0, 1'b1, eRSP_RDLINE, 12'd1, 4'b0001, 3'd5, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0101, 1'b0, 1'b1, eRSP_RDLINE, 12'd2, 4'b0100, 3'd5, 1'b0, 1'b0));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(1'b1, 4'b0101, 1'b1, 1'b0, eRSP_RDLINE, 12'd0, 4'b0000, 3'd5, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0101, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0001, 3'd5, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0010, 3'd6, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0000, 3'd7, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b1, eRSP_RDLINE, 12'd3, 4'b0000, 3'd7, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0100, 3'd6, 1'b0, 1'b0));

      #12;
      chk_reset_vals("por");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      foreach (tbl[i]) run_vec(tbl[i]);

      // Asynchronous reset while a request is on the channel
      #2;
      chk("pre_reset_tx_valid", tx.valid, 1'b1);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("async");
      chk("async_req_ready", bus.req_ready, 4'b0000);
      txq.delete();
      rspq.delete();
      idle_inputs();
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Three reads, disable, out-of-order completions, drain
      run_vec(mk(1'b1, 4'b0111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0000, 3'd0, 1'b0, 1'b0));
      run_vec(mk(1'b1, 4'b0111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0001, 3'd0, 1'b0, 1'b0));
      run_vec(mk(1'b1, 4'b0111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0010, 3'd1, 1'b0, 1'b0));
      run_vec(mk(1'b1, 4'b0111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0100, 3'd2, 1'b0, 1'b0));
      run_vec(mk(1'b0, 4'b0111, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0000, 3'd3, 1'b0, 1'b0));
      run_vec(mk(1'b0, 4'b0000, 1'b0, 1'b1, eRSP_RDLINE, 12'd2, 4'b0000, 3'd3, 1'b0, 1'b0));
      run_vec(mk(1'b0, 4'b0000, 1'b0, 1'b1, eRSP_RDLINE, 12'd0, 4'b0000, 3'd2, 1'b0, 1'b0));
      run_vec(mk(1'b0, 4'b0000, 1'b0, 1'b1, eRSP_RDLINE, 12'd1, 4'b0000, 3'd1, 1'b0, 1'b0));
      run_vec(mk(1'b0, 4'b0000, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0000, 3'd0, 1'b0, 1'b0));
      run_vec(mk(1'b0, 4'b0000, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0000, 3'd0, 1'b1, 1'b0));

      // Re-enable, bad tag dropped, non-RDLINE ignored, then a stale completion
      run_vec(mk(1'b1, 4'b0001, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0000, 3'd0, 1'b1, 1'b0));
      run_vec(mk(1'b1, 4'b0001, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0001, 3'd0, 1'b0, 1'b0));
      run_vec(mk(1'b1, 4'b0000, 1'b0, 1'b1, eRSP_RDLINE, 12'd5, 4'b0000, 3'd1, 1'b0, 1'b0));
      run_vec(mk(1'b1, 4'b0000, 1'b0, 1'b1, eRSP_UMSG,   12'd0, 4'b0000, 3'd1, 1'b0, 1'b1));
      run_vec(mk(1'b1, 4'b0000, 1'b0, 1'b1, eRSP_RDLINE, 12'd0, 4'b0000, 3'd1, 1'b0, 1'b1));
      run_vec(mk(1'b1, 4'b0000, 1'b0, 1'b1, eRSP_RDLINE, 12'd1, 4'b0000, 3'd0, 1'b0, 1'b1));
      run_vec(mk(1'b1, 4'b0000, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0000, 3'd0, 1'b0, 1'b1));

      // Fresh reset, then a completion nobody asked for
      reset_n = 1'b0;
      #1;
      chk("rst2_error", error, 1'b0);
      txq.delete();
      rspq.delete();
      idle_inputs();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      run_vec(mk(1'b0, 4'b0000, 1'b0, 1'b1, eRSP_RDLINE, 12'd2, 4'b0000, 3'd0, 1'b0, 1'b0));
      run_vec(mk(1'b0, 4'b0000, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0000, 3'd0, 1'b0, 1'b1));
      run_vec(mk(1'b0, 4'b0000, 1'b0, 1'b0, eRSP_RDLINE, 12'd0, 4'b0000, 3'd0, 1'b0, 1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
